// File: rtl/warp_inst_queue.sv
// Instruction queue between fetch and decode: 1-2 instructions in and out per cycle, single-cycle flush.
// Optional combinational empty-queue bypass enabled by defining WARP_IQ_BYPASS_EN.
module warp_inst_queue #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [31:0]              i_inst0,
   input  logic [31:0]              i_inst1,
   input  logic [1:0]               i_compressed,
   input  logic                     i_count,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [31:0]              o_inst0,
   output logic [31:0]              o_inst1,
   output logic [1:0]               o_compressed,
   output logic                     o_count,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr_nx1;
   logic [AW-1:0] wptr_nx1;
   logic [LW-1:0] level;
   logic [LW-1:0] free;
   logic [LW-1:0] enq_n;
   logic [LW-1:0] deq_n;
   logic          q_valid;
   logic          q_two;
   logic          enq;
   logic          deq;
   logic          byp_take;

   assign rptr_nx1 = rptr + AW'(1);
   assign wptr_nx1 = wptr + AW'(1);
   assign free     = LW'(DEPTH) - level;
   assign o_ready  = !i_flush && (free >= LW'(2));
   assign o_level  = level;

   assign q_valid  = !i_flush && (level != '0);
   assign q_two    = level >= LW'(2);
   assign enq_n    = i_count ? LW'(2) : LW'(1);
   assign deq_n    = q_two ? LW'(2) : LW'(1);
   assign deq      = q_valid && i_ready;

`ifdef WARP_IQ_BYPASS_EN
   // A bundle consumed straight off the bypass path must not also be stored.
   assign byp_take = !i_flush && (level == '0) && i_valid && i_ready;
`else
   assign byp_take = 1'b0;
`endif

   assign enq = i_valid && o_ready && !byp_take;

   always_comb begin
      o_valid      = 1'b0;
      o_count      = 1'b0;
      o_inst0      = '0;
      o_inst1      = '0;
      o_compressed = '0;
      if (q_valid) begin
         o_valid         = 1'b1;
         o_count         = q_two;
         o_inst0         = mem[rptr][31:0];
         o_compressed[0] = mem[rptr][32];
         if (q_two) begin
            o_inst1         = mem[rptr_nx1][31:0];
            o_compressed[1] = mem[rptr_nx1][32];
         end
      end
`ifdef WARP_IQ_BYPASS_EN
      else if (!i_flush && (level == '0) && i_valid) begin
         o_valid         = 1'b1;
         o_count         = i_count;
         o_inst0         = i_inst0;
         o_compressed[0] = i_compressed[0];
         if (i_count) begin
            o_inst1         = i_inst1;
            o_compressed[1] = i_compressed[1];
         end
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
      end else if (i_flush) begin
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
      end else begin
         if (enq) wptr <= wptr + AW'(enq_n);
         if (deq) rptr <= rptr + AW'(deq_n);
         level <= level + (enq ? enq_n : '0) - (deq ? deq_n : '0);
      end
   end

   // Storage is not reset; contents are only observed through valid pointers.
   always_ff @(posedge i_clk) begin
      if (enq) begin
         mem[wptr] <= {i_compressed[0], i_inst0};
         if (i_count) mem[wptr_nx1] <= {i_compressed[1], i_inst1};
      end
   end

endmodule
